// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose:
//   Adds two unsigned WIDTH-bit operands plus a carry-in, one nibble per clock.
//   Each nibble goes through a 4-bit carry-lookahead slice. The slice's
//   carry-out is kept as a running carry for the next nibble. An operand set
//   is accepted in IDLE. The block then spends WIDTH/4 cycles in RUN and
//   presents the result in DONE until the consumer takes it.
//
// Parameters:
//   WIDTH      operand/sum width in bits (multiple of 4, >= 4), default 16
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand set valid
//   in_ready   high only in IDLE
//   a, b       unsigned operands
//   cin        carry into nibble 0
//   out_valid  high only in DONE
//   out_ready  consumer accepts result (only looked at in DONE)
//   sum        registered a+b+cin, low WIDTH bits
//   cout       carry out of the top nibble
//   ovf        signed overflow flag (only when OVF_FLAG_EN is defined)
//
// Build option:
//   OVF_FLAG_EN  when defined, adds the ovf port and its register.
// ---------------------------------------------------------------------------
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
`ifdef OVF_FLAG_EN
  logic             ovf_reg, ovf_next;
`endif

  // Split the captured operands into nibble lanes.
  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];

  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

  // Carry-lookahead slice for the nibble selected by the counter.
  logic [3:0] cur_a, cur_b, p, g, s;
  logic [4:0] c;

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int k = 0; k < NIB; k++) begin
      if (cnt_reg == CW'(k)) begin
        cur_a = a_nib[k];
        cur_b = b_nib[k];
      end
    end
  end

  assign p    = cur_a ^ cur_b;
  assign g    = cur_a & cur_b;
  assign c[0] = carry_reg;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];

  // Next-state and datapath updates.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    cnt_next   = cnt_reg;
`ifdef OVF_FLAG_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = b;
          carry_next = cin;
          cnt_next   = '0;
          sum_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NIB; k++) begin
          if (cnt_reg == CW'(k)) begin
            sum_next[4*k +: 4] = s;
          end
        end
        carry_next = c[4];
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == CW'(NIB - 1)) begin
          cout_next  = c[4];
`ifdef OVF_FLAG_EN
          // c[3] of the top slice is the carry into the sum MSB.
          ovf_next   = c[3] ^ c[4];
`endif
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
`ifdef OVF_FLAG_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      cnt_reg   <= cnt_next;
`ifdef OVF_FLAG_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
`ifdef OVF_FLAG_EN
  assign ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder
//
// Self-checking bench for nibble_serial_adder (WIDTH=16). It runs a table of
// directed vectors, then sequences for a stall in DONE and for a reset during
// RUN, and then random operand sets. The random sets are checked against an
// arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: accept, measure latency, check result, hold it
  // in DONE for 'stall' cycles while stirring the inputs, then hand it off.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input int stall,
                       input logic [W-1:0] esum, input logic ecout,
                       input logic eovf, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk({nm, "_wait_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    cin       = tc;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    // Scramble the operands after the accepting edge; they must not matter.
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom_range(0, 1));
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd4);
    chk({nm, "_sum"}, 32'(sum), 32'(esum));
    chk({nm, "_cout"}, 32'(cout), 32'(ecout));
`ifdef OVF_FLAG_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) chk({nm, "_ovf_x"}, 32'(eovf), 32'd0);
`endif
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'(i % 2);
      a        = W'($urandom);
      b        = W'($urandom);
      tick();
      chk({nm, "_stall_sum"}, 32'(sum), 32'(esum));
      chk({nm, "_stall_in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, "_stall_out_valid"}, 32'(out_valid), 32'd1);
    end
    // Keep in_valid high on the handshake edge; it must not be accepted there.
    in_valid  = (stall > 0);
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk({nm, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    $display("op %s a=0x%04h b=0x%04h cin=%0d sum=0x%04h cout=%0d stall=%0d",
             nm, ta, tb_v, tc, esum, ecout, stall);
  endtask

  initial begin
    logic [W:0]   full;
    logic [W-1:0] ra, rb;
    logic         rc, rovf;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
`ifdef OVF_FLAG_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // The first accept happens on the first edge after reset release.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, 0,
            vecs[i].esum, vecs[i].ecout, vecs[i].eovf, $sformatf("vec%0d", i));
    end

    // Result held across a 5-cycle stall with inputs toggling.
    do_op(16'h1234, 16'h4321, 1'b0, 5, 16'h5555, 1'b0, 1'b0, "stall5");

    // Reset pulse during RUN cycle 2 aborts the operation.
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    cin = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
`ifdef OVF_FLAG_EN
    chk("abort_ovf", 32'(ovf), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    do_op(16'h0001, 16'h0001, 1'b0, 0, 16'h0002, 1'b0, 1'b0, "after_abort");

    // Random operand sets against the arithmetic reference model.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      rovf = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      do_op(ra, rb, rc, int'($urandom_range(0, 3)), full[W-1:0], full[W],
            rovf, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
